// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit-side UART serializer. It accepts one parallel word when
// data_valid is high in IDLE. It then shifts out one frame, LSB first, one
// bit per rising edge of clk:
//   start (0) | DATA_WIDTH data bits | optional parity bit | stop (1)
//
// clk is the TX bit clock, which the upstream baud divider supplies. Each
// rising edge is one bit period.
//
// Ports:
//   clk        in   TX bit clock
//   rst        in   asynchronous active-low reset
//   p_data     in   parallel word to transmit (sampled on acceptance)
//   data_valid in   request strobe; accepted only while idle
//   par_en     in   1 = append a parity bit after the data bits
//   par_typ    in   0 = even parity, 1 = odd parity
//   tx_out     out  serial line, idles high (registered)
//   busy       out  high for every bit period of a frame (registered)
//
// The state register always names the bit that tx_out is currently
// driving. The outputs are registered from the next-state logic, so the
// start bit appears on the same edge that accepts the request. No input
// reaches an output combinationally.
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  par_en_reg;
  logic                  par_en_nxt;
  logic                  par_bit_reg;
  logic                  par_bit_nxt;
  logic                  tx_nxt;
  logic                  busy_nxt;

  // Even parity makes the total number of ones (data + parity) even, so the
  // parity bit is the XOR of the data. Odd parity inverts that bit.
  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d,
                                     input logic                  odd);
    return (^d) ^ odd;
  endfunction

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    data_nxt    = data_reg;
    par_en_nxt  = par_en_reg;
    par_bit_nxt = par_bit_reg;
    tx_nxt      = 1'b1;
    busy_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (data_valid) begin
          // Capture the whole frame configuration now. Later changes to the
          // inputs cannot disturb the frame in flight.
          data_nxt    = p_data;
          par_en_nxt  = par_en;
          par_bit_nxt = parity_of(p_data, par_typ);
          bit_cnt_nxt = '0;
          state_nxt   = START;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
        end
      end

      START: begin
        state_nxt   = DATA;
        bit_cnt_nxt = '0;
        tx_nxt      = data_reg[0];
        busy_nxt    = 1'b1;
      end

      DATA: begin
        busy_nxt = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_nxt = '0;
          if (par_en_reg) begin
            state_nxt = PARITY;
            tx_nxt    = par_bit_reg;
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          tx_nxt      = data_reg[bit_cnt_nxt];
        end
      end

      PARITY: begin
        state_nxt = STOP;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b1;
      end

      // Leaving STOP always spends one cycle in IDLE, with the line high.
      // That cycle is the minimum inter-frame gap.
      STOP: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      tx_out      <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      data_reg    <= data_nxt;
      par_en_reg  <= par_en_nxt;
      par_bit_reg <= par_bit_nxt;
      tx_out      <= tx_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit-side serializer; the counterpart of the receive path's sampling/deserializing chain.
- Accepts one parallel byte under a valid strobe.
- Emits a frame on tx_out, LSB first: start bit, DATA_WIDTH data bits, optional parity bit, one stop bit.
- Runs on the TX clock domain, one clock per bit. The baud-rate divider upstream provides clk.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..9)

Ports:
- clk  input  1  TX bit clock; one bit period per rising edge
- rst  input  1  asynchronous active-low reset
- p_data  input  DATA_WIDTH  parallel byte to transmit
- data_valid  input  1  request strobe; p_data/par_en/par_typ are sampled when accepted
- par_en  input  1  1 = insert parity bit after data
- par_typ  input  1  0 = even parity, 1 = odd parity
- tx_out  output  1  serial line; idles high
- busy  output  1  high while a frame is in progress

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately):
  - tx_out = 1, busy = 0, state = IDLE.
  - Bit counter = 0; data and config holding registers cleared.
- tx_out and busy are registered; no combinational path from inputs to outputs.
- FSM states and transitions:
  - IDLE:
    - tx_out = 1, busy = 0.
    - If data_valid = 1 at a rising edge: latch p_data, par_en, par_typ; compute parity from the latched data; go to START.
    - If data_valid = 0: stay in IDLE.
  - START: tx_out = 0, busy = 1, one cycle, then DATA with bit counter = 0.
  - DATA:
    - tx_out = data_reg[bit counter], busy = 1.
    - Counter increments each cycle.
    - After bit DATA_WIDTH-1: go to PARITY if the latched par_en = 1, else STOP.
  - PARITY:
    - tx_out = (XOR of the latched data) XOR par_typ, busy = 1, one cycle, then STOP.
    - Even parity: total ones in data+parity is even. Odd parity: total is odd.
  - STOP: tx_out = 1, busy = 1, one cycle, then IDLE.
- Latency: data_valid sampled high at edge N in IDLE → start bit on tx_out and busy = 1 from edge N until edge N+1.
- Frame length: DATA_WIDTH+2 cycles (no parity) or DATA_WIDTH+3 cycles (parity).
- busy falls at the edge that leaves STOP. The minimum gap between frames is one IDLE cycle with tx_out = 1.
- Requests are accepted only in IDLE:
  - data_valid while busy = 1 is ignored and is not queued.
  - Changes to p_data, par_en or par_typ mid-frame do not affect the frame in flight.
- data_valid held high continuously: a new frame starts on every IDLE cycle, i.e. back-to-back frames separated by exactly one idle bit.
- Reset mid-frame: the frame is aborted, tx_out returns to 1 asynchronously, and no partial state survives. The first data_valid after reset release starts a fresh frame.
- Bit counter width: ceil(log2(DATA_WIDTH)); it never wraps during a valid frame.

Test Plan:
- Reset, then p_data = 0xA5, par_en = 0, one-cycle data_valid → tx_out = 0,1,0,1,0,0,1,0,1,1 over 10 cycles, then stays 1. busy = 1 for exactly those 10 cycles.
- p_data = 0xA5, par_en = 1, par_typ = 0 → 11-bit frame with parity bit 0. Repeat with par_typ = 1 → parity bit 1. Check p_data = 0x07 even → parity bit 1.
- Start a frame with 0x3C, then pulse data_valid with p_data = 0xFF at cycle 4 and change par_en mid-frame → the 0x3C frame is unaltered, no second frame follows, busy drops after the stop bit.
- data_valid held high with p_data = 0x55 then 0x0F, par_en = 0 → frames 0,1,0,1,0,1,0,1,0,1 | idle 1 | 0,1,1,1,1,0,0,0,0,1. Acceptance happens in the idle cycle.
- Assert rst low during data bit 3 of 0x00 → tx_out = 1 and busy = 0 immediately, without waiting for a clock. After release with data_valid = 0, tx_out stays 1 indefinitely.
- Random p_data/par_en/par_typ over 1000 frames against a reference model; decode the serial stream and check data, parity, stop bit = 1, and frame length of 10 or 11 cycles.
